// File: rtl/md_init_ctrl.sv
// Particle-init load sequencer: gates the host init stream into the loader, mirrors
// its step/address counters and flags tlast mismatches. Optional stall timeout: MD_INIT_CTRL_TIMEOUT_EN.
module md_init_ctrl #(
   parameter int NUM_INIT_STEPS    = 8,
   parameter int INIT_STEP_WIDTH   = 3,
   parameter int PARTICLE_ID_WIDTH = 8,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_start,
   input  logic [PARTICLE_ID_WIDTH-1:0] i_npc,
   input  logic                         s_tvalid,
   input  logic                         s_tlast,
   output logic                         s_tready,
   output logic                         o_ld_tvalid,
   output logic                         o_ld_rst,
   output logic [INIT_STEP_WIDTH-1:0]   o_step,
   output logic [PARTICLE_ID_WIDTH-1:0] o_addr,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err
);

   // state | meaning
   // IDLE  | loader held in reset, waiting for i_start
   // CLEAR | one cycle: loader reset, step/addr cleared
   // LOAD  | stream open, counting beats
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_DONE} state_t;

   localparam logic [INIT_STEP_WIDTH-1:0] LAST_STEP = INIT_STEP_WIDTH'(NUM_INIT_STEPS - 1);

   state_t                         state, state_nxt;
   logic [PARTICLE_ID_WIDTH-1:0]   npc;
   logic [INIT_STEP_WIDTH-1:0]     step;
   logic [PARTICLE_ID_WIDTH-1:0]   addr;
   logic                           err;
   logic                           accept;
   logic                           last_addr;
   logic                           final_beat;
   logic                           timeout;

   assign accept     = (state == ST_LOAD) & s_tvalid;
   assign last_addr  = (addr >= npc);
   assign final_beat = accept & last_addr & (step == LAST_STEP);

`ifdef MD_INIT_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] stall_cnt;

   // Down-counter of stall cycles still allowed; fires on the last permitted stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= CNT_LOAD;
      end else if (state == ST_CLEAR || accept) begin
         stall_cnt <= CNT_LOAD;
      end else if (state == ST_LOAD) begin
         stall_cnt <= stall_cnt - CNT_W'(1);
      end
   end

   assign timeout = (state == ST_LOAD) & ~s_tvalid & (stall_cnt == CNT_W'(1));
`else
   // No stall limit in this build; the term only keeps the parameter referenced.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_tready  = 1'b0;
      o_ld_rst  = 1'b1;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            o_busy    = 1'b1;
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            o_busy   = 1'b1;
            s_tready = 1'b1;
            o_ld_rst = 1'b0;
            if (final_beat || timeout) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_done    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_ld_tvalid = s_tvalid & s_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         npc  <= '0;
         step <= '0;
         addr <= '0;
         err  <= 1'b0;
      end else begin
         if (state == ST_IDLE && i_start) begin
            npc <= i_npc;
            err <= 1'b0;
         end
         if (state == ST_CLEAR) begin
            step <= '0;
            addr <= '0;
         end
         if (accept) begin
            if (last_addr) begin
               addr <= '0;
               step <= final_beat ? '0 : step + INIT_STEP_WIDTH'(1);
            end else begin
               addr <= addr + PARTICLE_ID_WIDTH'(1);
            end
            // Beat count is authoritative; tlast only has to agree with it.
            if (s_tlast != final_beat) err <= 1'b1;
         end
         if (timeout) err <= 1'b1;
      end
   end

   assign o_step = step;
   assign o_addr = addr;
   assign o_err  = err;

endmodule

// File: tb/tb_md_init_ctrl.sv
// Scoreboard bench for md_init_ctrl: expected step/addr pushed per driven beat,
// popped and compared after the accepting edge.
module tb_md_init_ctrl;
   localparam int NS = 8;
   localparam int SW = 3;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [PW-1:0] i_npc;
   logic          s_tvalid;
   logic          s_tlast;
   logic          s_tready;
   logic          o_ld_tvalid;
   logic          o_ld_rst;
   logic [SW-1:0] o_step;
   logic [PW-1:0] o_addr;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   md_init_ctrl #(
      .NUM_INIT_STEPS(NS), .INIT_STEP_WIDTH(SW),
      .PARTICLE_ID_WIDTH(PW), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_npc(i_npc),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .o_ld_tvalid(o_ld_tvalid), .o_ld_rst(o_ld_rst), .o_step(o_step),
      .o_addr(o_addr), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SW-1:0] step;
      logic [PW-1:0] addr;
   } exp_t;

   exp_t          exp_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   logic [PW-1:0] m_npc;
   logic [SW-1:0] m_step;
   logic [PW-1:0] m_addr;
   logic          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tready"}, 32'(s_tready), 0);
      check({tag, "_ld_rst"}, 32'(o_ld_rst), 1);
      check({tag, "_busy"},   32'(o_busy), 0);
      check({tag, "_done"},   32'(o_done), 0);
   endtask

   task automatic start(input logic [PW-1:0] npc);
      i_start = 1'b1;
      i_npc   = npc;
      tick();
      i_start = 1'b0;
      i_npc   = PW'($urandom);
      m_npc  = npc;
      m_err  = 1'b0;
      m_step = '0;
      m_addr = '0;
      check("clr_busy",   32'(o_busy), 1);
      check("clr_ld_rst", 32'(o_ld_rst), 1);
      check("clr_tready", 32'(s_tready), 0);
      check("clr_err",    32'(o_err), 0);
      tick();
      check("load_tready", 32'(s_tready), 1);
      check("load_ld_rst", 32'(o_ld_rst), 0);
      check("load_step",   32'(o_step), 0);
      check("load_addr",   32'(o_addr), 0);
   endtask

   task automatic beat(input logic v, input logic l, output logic fin);
      exp_t e;
      fin = 1'b0;
      s_tvalid = v;
      s_tlast  = l;
      #1;
      check("ld_tvalid", 32'(o_ld_tvalid), 32'(v));
      if (v) begin
         fin = (m_step == SW'(NS - 1)) && (m_addr >= m_npc);
         if (l != fin) m_err = 1'b1;
         if (m_addr >= m_npc) begin
            m_addr = '0;
            m_step = fin ? '0 : m_step + 1'b1;
         end else begin
            m_addr = m_addr + 1'b1;
         end
         exp_q.push_back('{step: m_step, addr: m_addr});
      end
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (v) begin
         e = exp_q.pop_front();
         check("step", 32'(o_step), 32'(e.step));
         check("addr", 32'(o_addr), 32'(e.addr));
      end else begin
         check("hold_step", 32'(o_step), 32'(m_step));
         check("hold_addr", 32'(o_addr), 32'(m_addr));
      end
      check("done", 32'(o_done), 32'(fin));
      check("err",  32'(o_err), 32'(m_err));
      if (fin) check("done_tready", 32'(s_tready), 0);
   endtask

   // busy_at: beat index during which a stray i_start (npc=7) is pulsed; 0 = none.
   task automatic run_load(input logic [PW-1:0] npc, input int n, input int last_pos,
                           input bit gaps, input int busy_at);
      logic f;
      start(npc);
      for (int k = 1; k <= n; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) beat(1'b0, 1'b0, f);
         end
         if (k == busy_at) begin
            i_start = 1'b1;
            i_npc   = 8'd7;
         end
         beat(1'b1, (k == last_pos), f);
         i_start = 1'b0;
      end
      tick();
      check_idle("post");
      check("post_err", 32'(o_err), 32'(m_err));
   endtask

   initial begin
      logic f;
      rst = 1'b1; i_start = 1'b0; i_npc = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      tick(); tick();
      check_idle("rst");
      check("rst_step", 32'(o_step), 0);
      check("rst_addr", 32'(o_addr), 0);
      check("rst_err",  32'(o_err), 0);
      rst = 1'b0;
      tick();
      check_idle("idle");

      run_load(8'd3, 32, 32, 1'b0, 0);        // nominal
      run_load(8'd1, 16, 16, 1'b1, 0);        // bubbles
      run_load(8'd0, 8, 5, 1'b0, 0);          // early tlast
      check("err_sticky", 32'(o_err), 1);
      tick();
      check("err_sticky2", 32'(o_err), 1);
      run_load(8'd0, 8, 0, 1'b0, 0);          // missing tlast (start clears err)
      run_load(8'd255, 2048, 2048, 1'b0, 0);  // npc all-ones
      run_load(8'd3, 32, 32, 1'b0, 6);        // start while busy

      // reset mid-load
      start(8'd3);
      for (int k = 1; k <= 10; k++) beat(1'b1, 1'b0, f);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("midrst");
      check("midrst_step", 32'(o_step), 0);
      check("midrst_addr", 32'(o_addr), 0);
      check("midrst_err",  32'(o_err), 0);
      run_load(8'd3, 32, 32, 1'b0, 0);

`ifdef MD_INIT_CTRL_TIMEOUT_EN
      start(8'd3);
      for (int k = 1; k <= 3; k++) beat(1'b1, 1'b0, f);
      for (int k = 1; k <= 15; k++) beat(1'b0, 1'b0, f);
      tick();
      check("to_done", 32'(o_done), 1);
      check("to_err",  32'(o_err), 1);
      tick();
      check_idle("to_idle");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/md_init_ctrl.md
Name: md_init_ctrl

Overview:
- Sequences the particle-initialization load phase: accepts the host init AXI-stream, gates beats into the per-cell init loader, tracks the loader's write address and init step, and signals completion to the MD iteration controller.
- Sits between the host stream interface and the init loader / position caches.
- Owns loader reset and beat-count/tlast checking, so the loader itself stays purely datapath.

Parameters:
- NUM_INIT_STEPS, 8, number of init steps; each step loads 4 cells.
- INIT_STEP_WIDTH, 3, width of step index; must be at least clog2(NUM_INIT_STEPS).
- PARTICLE_ID_WIDTH, 8, width of per-cell particle address and particle count.
- TIMEOUT_CYCLES, 4096, stall limit used only when the optional feature is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  one-cycle pulse: begin an init load; ignored unless in IDLE
- i_npc  in  PARTICLE_ID_WIDTH  particles-per-cell value; sampled on i_start
- s_tvalid  in  1  host init stream valid
- s_tlast  in  1  host init stream last beat
- s_tready  out  1  host init stream ready
- o_ld_tvalid  out  1  gated valid to loader (s_tvalid & s_tready)
- o_ld_rst  out  1  loader synchronous reset
- o_step  out  INIT_STEP_WIDTH  mirror of loader's current step
- o_addr  out  PARTICLE_ID_WIDTH  mirror of loader's current write address
- o_busy  out  1  high from CLEAR through LOAD
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky tlast-mismatch flag; cleared on next accepted i_start

Behaviour:
- States: IDLE, CLEAR, LOAD, DONE.
- Reset values:
  - State = IDLE.
  - s_tready = 0, o_ld_tvalid = 0, o_ld_rst = 1, o_busy = 0, o_done = 0, o_err = 0.
  - o_step = 0, o_addr = 0; latched npc = 0.
- IDLE:
  - o_ld_rst = 1, s_tready = 0.
  - i_start → latch i_npc, clear o_err, go to CLEAR.
- CLEAR:
  - Exactly one cycle; o_ld_rst = 1, o_step/o_addr forced to 0.
  - Unconditionally go to LOAD.
- LOAD:
  - o_ld_rst = 0, s_tready = 1, o_ld_tvalid = s_tvalid.
  - On each accepted beat:
    - If o_addr >= npc: o_addr ← 0, o_step ← o_step+1.
    - Else: o_addr ← o_addr+1.
  - This exactly matches the loader's address/step update rule, so beats per step = npc+1 and total beats = NUM_INIT_STEPS*(npc+1).
- Final beat: the accepted beat where o_step = NUM_INIT_STEPS-1 and o_addr >= npc.
  - Go to DONE; o_step wraps to 0.
- tlast checking:
  - s_tlast=1 on any non-final accepted beat → o_err set.
  - s_tlast=0 on the final beat → o_err set.
  - Loading continues regardless; the count of beats is authoritative.
- DONE:
  - o_done = 1 for exactly one cycle, s_tready = 0.
  - Next state IDLE.
  - Latency: o_done asserts the cycle after the final beat is accepted.
- npc = 0: one beat per step; total NUM_INIT_STEPS beats.
- npc = all-ones: o_addr reaches max and the step advances; there is no overflow of o_addr.
- s_tvalid low in LOAD: counters hold; no timeout without the optional feature.
- i_start while not IDLE: ignored; no state or latched npc change.
- rst mid-LOAD: next cycle all outputs at reset values; partially loaded data abandoned; loader held in reset.
- o_busy = (state==CLEAR) | (state==LOAD).

Optional Feature:
- Macro: MD_INIT_CTRL_TIMEOUT_EN.
- Enabled:
  - Stall counter increments each LOAD cycle with no accepted beat; it resets on an accepted beat.
  - When the counter reaches TIMEOUT_CYCLES: set o_err, go to DONE, pulse o_done.
  - The loader remains in whatever state it reached, until the next CLEAR.
- Disabled:
  - No counter; LOAD waits indefinitely for beats; TIMEOUT_CYCLES unused.

Test Plan:
- Nominal load:
  - Stimulus: npc=3, i_start, 32 consecutive valid beats, tlast on beat 32.
  - Required response: o_step sequence 0..7 advancing every 4 beats; o_done pulses 1 cycle after beat 32; o_err=0; s_tready=0 afterwards.
- Bubbles:
  - Stimulus: npc=1, 16 beats with random s_tvalid gaps.
  - Required response: o_addr/o_step advance only on accepted beats; o_done after the 16th accepted beat.
- tlast errors:
  - Stimulus: npc=0, tlast on beat 5 of 8.
  - Required response: o_err=1 and sticky; load still completes after 8 beats; next i_start clears o_err.
  - Stimulus: npc=0, tlast missing on beat 8.
  - Required response: o_err=1.
- Reset mid-load:
  - Stimulus: rst asserted after 10 beats (npc=3).
  - Required response: next cycle o_step=0, o_addr=0, s_tready=0, o_ld_rst=1.
  - Follow-up: new i_start gives a full 32-beat load that completes normally.
- Start while busy:
  - Stimulus: i_start pulsed with i_npc=7 during LOAD (npc=3).
  - Required response: ignored; step still advances every 4 beats.
- Timeout (MD_INIT_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16):
  - Stimulus: 3 beats, then s_tvalid=0.
  - Required response: o_err=1 and o_done pulse 16 stall cycles later; state returns to IDLE.
